// File: rtl/aes_pkg.sv
// aes_pkg: shared AES constants and inverse key-schedule FSM states
package aes_pkg;
  localparam int NUM_ROUNDS = 10;
  localparam logic [7:0] RCON [16] = '{
    8'h00, 8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40,
    8'h80, 8'h1b, 8'h36, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00
  };
  typedef enum logic [1:0] {IDLE, ACTIVE, FINISH} state_t;
endpackage

// File: rtl/aes_sbox.sv
// aes_sbox: forward AES S-box lookup
module aes_sbox (
  input  logic [7:0] x,
  output logic [7:0] y
);
  localparam logic [7:0] SBOX [256] = '{
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };
  assign y = SBOX[x];
endmodule

// File: rtl/aes_inv_key_schedule.sv
// aes_inv_key_schedule: walks AES-128 round keys backwards from round 10 to round 0
module aes_inv_key_schedule
  import aes_pkg::*;
(
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [127:0] last_key,
  input  logic         key_ready,
  output logic [127:0] round_key,
  output logic [3:0]   round_idx,
  output logic         key_valid,
  output logic         busy,
  output logic         done
);
  state_t state, state_n;
  logic [127:0] key_n;
  logic [3:0] idx_n;
  logic valid_n, done_n;
  logic [31:0] p0, p1, p2, p3, rot, sub;
  assign p3 = round_key[31:0] ^ round_key[63:32];
  assign p2 = round_key[63:32] ^ round_key[95:64];
  assign p1 = round_key[95:64] ^ round_key[127:96];
  assign rot = {p3[23:0], p3[31:24]};
  for (genvar i = 0; i < 4; i++) begin : g_sbox
    aes_sbox u_sbox (.x(rot[8*i +: 8]), .y(sub[8*i +: 8]));
  end
  assign p0 = round_key[127:96] ^ sub ^ {RCON[round_idx], 24'h0};
  always_comb begin
    state_n = state;
    key_n = round_key;
    idx_n = round_idx;
    valid_n = 1'b0;
    done_n = 1'b0;
    if (state == IDLE && start) begin
      state_n = ACTIVE;
      key_n = last_key;
      idx_n = 4'(NUM_ROUNDS);
      valid_n = 1'b1;
    end else if (state == ACTIVE) begin
      valid_n = !(key_ready && round_idx == 4'd0);
      if (key_ready && round_idx == 4'd0) begin
        state_n = FINISH;
        done_n = 1'b1;
      end else if (key_ready) begin
        key_n = {p0, p1, p2, p3};
        idx_n = round_idx - 4'd1;
      end
    end else if (state == FINISH) begin
      state_n = IDLE;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      round_key <= '0;
      round_idx <= '0;
      key_valid <= 1'b0;
      busy <= 1'b0;
      done <= 1'b0;
    end else begin
      state <= state_n;
      round_key <= key_n;
      round_idx <= idx_n;
      key_valid <= valid_n;
      busy <= state_n != IDLE;
      done <= done_n;
    end
  end
endmodule

// File: tb/tb_aes_inv_key_schedule.sv
// tb_aes_inv_key_schedule: random and directed checks against a forward key-expansion model
module tb_aes_inv_key_schedule;
  logic clk = 1'b0, rst = 1'b1, start = 1'b0, key_ready = 1'b0;
  logic [127:0] last_key = '0, round_key;
  logic [3:0] round_idx;
  logic key_valid, busy, done;
  int n_cmp = 0, n_bad = 0;
  logic [7:0] sbt [256];
  logic [127:0] ek [11];

  always #5 clk = ~clk;

  aes_inv_key_schedule dut (
    .clk(clk), .rst(rst), .start(start), .last_key(last_key), .key_ready(key_ready),
    .round_key(round_key), .round_idx(round_idx), .key_valid(key_valid), .busy(busy), .done(done)
  );

  function automatic logic [7:0] xt(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gm(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00, x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p ^= x;
      x = xt(x);
    end
    return p;
  endfunction

  function automatic logic [7:0] rol(input logic [7:0] b, input int n);
    return (b << n) | (b >> (8 - n));
  endfunction

  // S-box from its definition: GF(2^8) inverse (a^254) followed by the affine map
  function automatic logic [7:0] sbf(input logic [7:0] a);
    logic [7:0] v = 8'h01;
    for (int i = 0; i < 254; i++) v = gm(v, a);
    return v ^ rol(v, 1) ^ rol(v, 2) ^ rol(v, 3) ^ rol(v, 4) ^ 8'h63;
  endfunction

  function automatic logic [127:0] rnd128();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic expand(input logic [127:0] key);
    logic [31:0] w [44];
    logic [31:0] t;
    logic [7:0] rc = 8'h01;
    for (int i = 0; i < 4; i++) w[i] = key[127 - 32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t = {t[23:0], t[31:24]};
        t = {sbt[t[31:24]], sbt[t[23:16]], sbt[t[15:8]], sbt[t[7:0]]} ^ {rc, 24'h0};
        rc = xt(rc);
      end
      w[i] = w[i-4] ^ t;
    end
    for (int r = 0; r < 11; r++) ek[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  endtask

  // starts a sequence from ek[10] at a negedge and checks every key until back in IDLE
  task automatic run_seq(input int stall_idx, input int stall_len, input bit hold);
    int e = 10, st = 0, cyc = 0;
    logic rdy;
    start = 1'b1;
    last_key = ek[10];
    @(negedge clk);
    cyc = 1;
    while (1) begin
      if (!hold) start = 1'b0;
      last_key = rnd128();
      chk("valid", 128'(key_valid), 128'(1));
      chk("idx", 128'(round_idx), 128'(e));
      chk($sformatf("key r%0d", e), round_key, ek[e]);
      chk("busy", 128'(busy), 128'(1));
      chk("done early", 128'(done), 128'(0));
      rdy = !(e == stall_idx && st < stall_len);
      if (!rdy) st++;
      key_ready = rdy;
      @(negedge clk);
      cyc++;
      if (rdy && e == 0) break;
      if (rdy) e--;
      if (cyc > 40) begin
        chk("timeout", 128'(cyc), 128'(0));
        break;
      end
    end
    chk("done pulse", 128'(done), 128'(1));
    chk("done cycle", 128'(cyc), 128'(12 + stall_len));
    chk("fin valid", 128'(key_valid), 128'(0));
    chk("fin busy", 128'(busy), 128'(1));
    chk("fin key", round_key, ek[0]);
    chk("fin idx", 128'(round_idx), 128'(0));
    key_ready = 1'($urandom_range(0, 1));
    @(negedge clk);
    chk("idle done", 128'(done), 128'(0));
    chk("idle busy", 128'(busy), 128'(0));
    chk("idle valid", 128'(key_valid), 128'(0));
    chk("idle key", round_key, ek[0]);
  endtask

  initial begin
    logic [127:0] lk;
    int guard;
    for (int i = 0; i < 256; i++) sbt[i] = sbf(8'(i));
    start = 1'b1;
    key_ready = 1'b1;
    last_key = rnd128();
    repeat (2) @(negedge clk);
    chk("rst key", round_key, 128'(0));
    chk("rst idx", 128'(round_idx), 128'(0));
    chk("rst valid", 128'(key_valid), 128'(0));
    chk("rst busy", 128'(busy), 128'(0));
    chk("rst done", 128'(done), 128'(0));
    rst = 1'b0;
    start = 1'b0;
    @(negedge clk);
    chk("idle stays", 128'(busy), 128'(0));

    expand(128'h2b7e1516_28aed2a6_abf71588_09cf4f3c);
    chk("fips model r10", ek[10], 128'hd014f9a8_c9ee2589_e13f0cc8_b6630ca6);
    chk("fips model r9", ek[9], 128'hac7766f3_19fadc21_28d12941_575c006e);
    chk("fips model r1", ek[1], 128'ha0fafe17_88542cb1_23a33939_2a6c7605);
    run_seq(-1, 0, 1'b0);

    expand(rnd128());
    run_seq(7, 5, 1'b0);

    expand(rnd128());
    run_seq(-1, 0, 1'b1);
    lk = last_key;
    @(negedge clk);
    chk("restart valid", 128'(key_valid), 128'(1));
    chk("restart idx", 128'(round_idx), 128'(10));
    chk("restart key", round_key, lk);
    start = 1'b0;
    key_ready = 1'b1;
    repeat (12) @(negedge clk);
    chk("restart drained", 128'(busy), 128'(0));

    expand(rnd128());
    start = 1'b1;
    last_key = ek[10];
    key_ready = 1'b1;
    @(negedge clk);
    start = 1'b0;
    guard = 0;
    while (round_idx != 4'd4 && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    chk("abort idx", 128'(round_idx), 128'(4));
    chk("abort key", round_key, ek[4]);
    rst = 1'b1;
    @(negedge clk);
    chk("abort rkey", round_key, 128'(0));
    chk("abort ridx", 128'(round_idx), 128'(0));
    chk("abort valid", 128'(key_valid), 128'(0));
    chk("abort busy", 128'(busy), 128'(0));
    chk("abort done", 128'(done), 128'(0));
    rst = 1'b0;
    @(negedge clk);
    chk("abort no done", 128'(done), 128'(0));
    chk("abort idle", 128'(busy), 128'(0));
    expand(rnd128());
    run_seq(-1, 0, 1'b0);

    for (int n = 0; n < 1000; n++) begin
      expand(rnd128());
      run_seq($urandom_range(0, 10), $urandom_range(0, 2), 1'b0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/aes_inv_key_schedule.md
AES_INV_KEY_SCHEDULE -- requirements
Module: aes_inv_key_schedule

Interface
REQ-001 SHALL have port clk, input, 1 bit: single clock; all state updates on rising edge.
REQ-002 SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-003 SHALL have port start, input, 1 bit: begin a reverse key sequence; sampled only in IDLE.
REQ-004 SHALL have port last_key, input, 128 bits: round-10 AES-128 key; word 0 = [127:96], byte 0 of each word = [31:24].
REQ-005 SHALL have port key_ready, input, 1 bit: consumer accepts the current round_key.
REQ-006 SHALL have port round_key, output, 128 bits: current round key, same word/byte order as last_key.
REQ-007 SHALL have port round_idx, output, 4 bits: AES round number of round_key, 10 down to 0.
REQ-008 SHALL have port key_valid, output, 1 bit: round_key/round_idx are valid.
REQ-009 SHALL have port busy, output, 1 bit: high in every state except IDLE.
REQ-010 SHALL have port done, output, 1 bit: one-cycle pulse after round-0 key is accepted.

Function
REQ-011 SHALL implement the FSM states IDLE, ACTIVE and FINISH.
REQ-012 IDLE with start=1: SHALL register last_key into round_key, set round_idx=10, key_valid=1, and go to ACTIVE on the next edge.
REQ-013 ACTIVE: key_valid SHALL be 1, and round_key/round_idx SHALL be held stable while key_ready=0.
REQ-014 ACTIVE with key_ready=1 and round_idx>0: SHALL load the previous round key and decrement round_idx, giving one key per cycle under continuous key_ready.
REQ-015 The previous-key rule for key words w0..w3 at round r SHALL be: p3=w3^w2, p2=w2^w1, p1=w1^w0, p0=w0^SubWord(RotWord(p3))^{Rcon[r],24'h0}.
REQ-016 RotWord({b0,b1,b2,b3}) SHALL equal {b1,b2,b3,b0}.
REQ-017 Rcon[1..10] SHALL be 01,02,04,08,10,20,40,80,1B,36.
REQ-018 ACTIVE with key_ready=1 and round_idx=0: SHALL clear key_valid and go to FINISH.
REQ-019 FINISH: SHALL assert done=1 for exactly one cycle, then return to IDLE.
REQ-020 start SHALL be ignored in ACTIVE and FINISH.
REQ-021 last_key SHALL be sampled only on the start cycle; later changes SHALL have no effect on the current sequence.
REQ-022 round_key and round_idx SHALL keep their last values in IDLE and FINISH; key_valid=0 in both states.
REQ-023 All outputs SHALL be driven from registers; combinational logic SHALL sit only on the next-key path.

Reset
REQ-024 With rst=1 at a clock edge, the block SHALL enter IDLE with round_key=0, round_idx=0, key_valid=0, busy=0 and done=0.
REQ-025 rst SHALL take priority over start and key_ready.
REQ-026 rst during ACTIVE SHALL abort the sequence with no done pulse.

Structure
REQ-027 The shared package aes_pkg SHALL hold the Rcon table, the FSM state enum and the constant NUM_ROUNDS=10.
REQ-028 SubWord SHALL use four instances of the shared combinational sub-module aes_sbox (8-bit in, 8-bit out, forward S-box).
REQ-029 The block SHALL contain no other sub-modules.

Verification
REQ-030 FIPS-197 key test, key_ready held 1: start with last_key=d014f9a8_c9ee2589_e13f0cc8_b6630ca6 -> round 10 on the cycle after start; round 9 = ac7766f3_19fadc21_28d12941_575c006e; round 1 = a0fafe17_88542cb1_23a33939_2a6c7605; round 0 = 2b7e1516_28aed2a6_abf71588_09cf4f3c; done pulses once, 12 cycles after start.
REQ-031 Backpressure: key_ready=0 for 5 cycles at round_idx=7 -> round_key and round_idx stay constant; the sequence then resumes with the correct round-6 key.
REQ-032 start held 1 throughout the sequence, with last_key changed mid-sequence -> the sequence is unaffected, and a single new sequence starts only after return to IDLE.
REQ-033 rst asserted at round_idx=4 -> the next cycle shows all outputs at zero, no done pulse, and the block is in IDLE; a new start then works.
REQ-034 Random keys (1000 cases): the model expands a random cipher key forward, starts with its round-10 key, and all 11 output keys match the model in reverse order.
